fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decoder.
- Holds the program counter and issues one 32-bit word read at a time to instruction memory over a valid/ready request channel plus a response channel.
- Presents the fetched word and its PC to decode over a valid/ready handshake; the word drives the decoder's `encoded` input.
- Accepts redirects (jumps, taken branches) from execute, discards stale in-flight responses, and flags misaligned targets.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_addr  output  32  word-aligned fetch address.
- mem_resp_valid  input  1  read data returned; one-cycle pulse, no backpressure.
- mem_resp_data  input  32  instruction word.
- redirect_valid  input  1  PC override from execute.
- redirect_pc  input  32  new PC.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode consumes the instruction.
- inst_encoded  output  32  fetched instruction word.
- inst_pc  output  32  address of inst_encoded.
- misaligned_fault  output  1  redirect target not 4-byte aligned.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - pc=RESET_VECTOR, state=REQUEST, drop_pending=0.
  - mem_req_valid=0, inst_valid=0, inst_encoded=0, inst_pc=0, misaligned_fault=0, mem_req_addr=RESET_VECTOR.
- At most one memory request outstanding. Only the state register and drop_pending gate issue.
- REQUEST state:
  - mem_req_valid=1 when drop_pending=0; mem_req_addr=pc.
  - Address is held stable until accepted.
  - On mem_req_valid&mem_req_ready -> WAIT_RESP.
- WAIT_RESP state: on mem_resp_valid, latch inst_encoded=mem_resp_data and inst_pc=pc, then -> HOLD.
- HOLD state:
  - inst_valid=1; outputs are held stable while inst_ready=0.
  - On inst_ready: pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), -> REQUEST.
- Latency: request accepted at cycle N with response at N+k gives inst_valid at N+k+1. Minimum 3 cycles per instruction with a zero-wait memory (k=1); no overlap.
- Redirect has priority over every other event in the same cycle:
  - pc<=redirect_pc.
  - inst_valid is 0 from the next cycle.
  - Next state is REQUEST, or FAULT if misaligned.
  - If a request is outstanding, drop_pending<=1. This covers WAIT_RESP, and also REQUEST when the request is accepted in the same cycle as the redirect.
- drop_pending:
  - Cleared on the next mem_resp_valid; that response is discarded and never reaches the decode outputs.
  - While set, mem_req_valid=0.
  - A response arriving in the same cycle as a redirect is discarded; drop_pending stays 0, since nothing remains outstanding.
- Redirect during HOLD with inst_ready=1 in the same cycle: the handshake completes for decode, but pc takes redirect_pc, not pc+4.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - -> FAULT; misaligned_fault=1, mem_req_valid=0, inst_valid=0.
  - An outstanding response is still drained via drop_pending.
  - FAULT is left only by an aligned redirect (-> REQUEST, misaligned_fault=0 next cycle); misaligned redirects in FAULT keep it set.
- mem_resp_valid with no outstanding request (protocol violation): ignored.
- Reset asserted mid-transaction: all state is cleared immediately. Any memory response arriving after reset release with no outstanding request is ignored.

Test Plan:
- Reset release, memory with ready=1 and 1-cycle response returning 32'h00000013 at 0x0 -> mem_req_addr 0x0; inst_valid with inst_pc=0x0 and inst_encoded=32'h00000013; next request to 0x4.
- Hold inst_ready=0 for 5 cycles in HOLD -> outputs stable, no new mem request; after inst_ready=1, next request to 0x4.
- Redirect to 0x100 while in WAIT_RESP, stale data 32'hDEADBEEF arrives 2 cycles later -> DEADBEEF never presented; next request to 0x100; inst_pc=0x100.
- Redirect to 0x202 -> misaligned_fault=1 and no requests; then redirect to 0x200 -> fault clears and a request issues to 0x200.
- Redirect to 0x40 in HOLD coincident with inst_ready=1 -> next request to 0x40, not pc+4.
- RESET_VECTOR=32'hFFFF_FFFC, consume one instruction -> next request to 0x0 (wrap).

Source files
------------

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage feeding the decoder. Holds the program counter,
// issues one 32-bit word read at a time to instruction memory, and presents
// the returned word together with its PC to decode. Redirects from execute
// override the PC, discard any response still in flight, and park the unit
// in FAULT when the target is not 4-byte aligned.
//
// Handshake semantics (both valid/ready channels): a transfer happens on a
// rising clock edge where valid and ready are both 1. Once valid is raised
// the payload stays constant until that transfer, unless a redirect cancels
// it. The response channel (mem_resp_valid/mem_resp_data) is a one-cycle
// pulse with no backpressure.
//
// Parameters:
//   RESET_VECTOR     PC loaded on reset (bits [1:0] must be 0)
//
// Ports:
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   mem_req_valid    fetch request valid               (out)
//   mem_req_ready    memory accepts the request        (in)
//   mem_req_addr     word-aligned fetch address        (out, 32)
//   mem_resp_valid   read data returned, 1-cycle pulse (in)
//   mem_resp_data    instruction word                  (in, 32)
//   redirect_valid   PC override from execute          (in)
//   redirect_pc      new PC                            (in, 32)
//   inst_valid       instruction available to decode   (out)
//   inst_ready       decode consumes the instruction   (in)
//   inst_encoded     fetched instruction word          (out, 32)
//   inst_pc          address of inst_encoded           (out, 32)
//   misaligned_fault redirect target not 4-byte aligned (out)
//   dbg_state        current FSM state                 (out, 2)
//   dbg_drop_pending a cancelled response is still owed (out)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_encoded,
    output logic [31:0] inst_pc,
    output logic        misaligned_fault,
    output logic [1:0]  dbg_state,
    output logic        dbg_drop_pending
);

    typedef enum logic [1:0] {
        S_REQUEST   = 2'd0,
        S_WAIT_RESP = 2'd1,
        S_HOLD      = 2'd2,
        S_FAULT     = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_drop_pending;
    logic [31:0] r_inst_encoded;
    logic [31:0] r_inst_pc;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_drop_nxt;
    logic        w_latch;
    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_outstanding;
    logic        w_misaligned;

    // Request is gated by reset as well so nothing is offered while the
    // unit is held in reset.
    assign w_req_valid  = (r_state == S_REQUEST) && !r_drop_pending && reset_n;
    assign w_req_fire   = w_req_valid && mem_req_ready;
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);

    // A request is still unanswered after this edge if it is accepted now,
    // if we are waiting and the response is not here yet, or if a cancelled
    // response is owed and has not arrived this cycle. A response that lands
    // in the same cycle as a redirect is simply dropped, so nothing remains.
    assign w_outstanding = w_req_fire
                         || ((r_state == S_WAIT_RESP) && !mem_resp_valid)
                         || (r_drop_pending && !mem_resp_valid);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop_pending && !mem_resp_valid;
        w_latch     = 1'b0;

        if (redirect_valid) begin
            // Redirect wins over every other event in the same cycle,
            // including a completing decode handshake or an arriving response.
            w_pc_nxt    = redirect_pc;
            w_drop_nxt  = w_outstanding;
            w_state_nxt = w_misaligned ? S_FAULT : S_REQUEST;
        end else begin
            unique case (r_state)
                S_REQUEST: begin
                    if (w_req_fire) begin
                        w_state_nxt = S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (mem_resp_valid && !r_drop_pending) begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        w_pc_nxt    = r_pc + 32'd4;
                        w_state_nxt = S_REQUEST;
                    end
                end
                S_FAULT: begin
                    // Left only through an aligned redirect.
                    w_state_nxt = S_FAULT;
                end
                default: begin
                    w_state_nxt = S_REQUEST;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_REQUEST;
            r_pc           <= RESET_VECTOR;
            r_drop_pending <= 1'b0;
            r_inst_encoded <= 32'h0;
            r_inst_pc      <= 32'h0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_drop_pending <= w_drop_nxt;
            if (w_latch) begin
                r_inst_encoded <= mem_resp_data;
                r_inst_pc      <= r_pc;
            end
        end
    end

    assign mem_req_valid    = w_req_valid;
    assign mem_req_addr     = r_pc;
    assign inst_valid       = (r_state == S_HOLD);
    assign inst_encoded     = r_inst_encoded;
    assign inst_pc          = r_inst_pc;
    assign misaligned_fault = (r_state == S_FAULT);
    assign dbg_state        = r_state;
    assign dbg_drop_pending = r_drop_pending;

endmodule
